// File: rtl/ref_mem_read_responder.sv
// ref_mem_read_responder
//
// Responder end of the DRAM read-burst interface. It accepts read requests
// (ID, byte address, beat count) into a small FIFO and streams 256-bit beats
// back from an internal memory image of DRAM. This lets the reference
// reader/engine chain run with no DRAM or bus arbiter behind it.
//
// Ports
//   clk, rst            single clock; synchronous active-high reset
//   rd_id_in            request burst ID
//   rd_addr_in          request byte address; bits [ADDR_WIDTH+4:5] form the word address
//   rd_len_in           request length in beats (0 = discard, no beats)
//   rd_info_valid_in    request valid
//   rd_info_rdy_out     request ready (low while FIFO full or in reset)
//   rd_data_out         beat data
//   rd_data_valid_out   beat valid
//   rd_data_rdy_in      beat consumed when high with valid
//   rd_data_id_out      ID of the burst the current beat belongs to
//   rd_data_last_out    final beat of its burst
//   mem_wr_en/addr/data preload write port into the memory image
//
// State table
//   state   | meaning
//   S_IDLE  | no burst loaded; next FIFO head is popped and its first read issued
//   S_BURST | burst loaded; one read issued per cycle while output credit exists

module ref_mem_read_responder #(
    parameter int ADDR_WIDTH     = 10,
    parameter int REQ_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            rd_id_in,
    input  logic [31:0]           rd_addr_in,
    input  logic [7:0]            rd_len_in,
    input  logic                  rd_info_valid_in,
    output logic                  rd_info_rdy_out,
    output logic [255:0]          rd_data_out,
    output logic                  rd_data_valid_out,
    input  logic                  rd_data_rdy_in,
    output logic [5:0]            rd_data_id_out,
    output logic                  rd_data_last_out,
    input  logic                  mem_wr_en,
    input  logic [ADDR_WIDTH-1:0] mem_wr_addr,
    input  logic [255:0]          mem_wr_data
);

    localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [5:0]            fifo_id   [REQ_FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_word [REQ_FIFO_DEPTH];
    logic [7:0]            fifo_len  [REQ_FIFO_DEPTH];
    logic [PTR_W-1:0]      fifo_wp, fifo_rp;
    logic [PTR_W:0]        fifo_cnt;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ADDR_WIDTH-1:0] req_word;
    logic                  addr_bits_unused;

    logic [5:0]            head_id;
    logic [ADDR_WIDTH-1:0] head_word;
    logic [7:0]            head_len;

    assign req_word         = rd_addr_in[ADDR_WIDTH+4:5];
    assign addr_bits_unused = ^{rd_addr_in[31:ADDR_WIDTH+5], rd_addr_in[4:0]};

    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(REQ_FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);

    // Ready looks only at registered occupancy, so a same-cycle pop does not
    // reopen a full FIFO.
    assign rd_info_rdy_out = !rst && !fifo_full;
    assign fifo_push       = rd_info_valid_in && rd_info_rdy_out;

    assign head_id   = fifo_id[fifo_rp];
    assign head_word = fifo_word[fifo_rp];
    assign head_len  = fifo_len[fifo_rp];

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_id[fifo_wp]   <= rd_id_in;
            fifo_word[fifo_wp] <= req_word;
            fifo_len[fifo_wp]  <= rd_len_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) fifo_wp <= fifo_wp + PTR_W'(1);
            if (fifo_pop)  fifo_rp <= fifo_rp + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory read stage and 2-entry output skid buffer
    // ------------------------------------------------------------------
    logic [255:0]          mem [2**ADDR_WIDTH];
    logic [255:0]          mem_q;
    logic                  mem_vld_q, mem_last_q;
    logic [5:0]            mem_id_q;

    logic                  rd_issue, rd_beat_last;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic [5:0]            rd_beat_id;

    logic [255:0]          skid_data [2];
    logic [5:0]            skid_id   [2];
    logic                  skid_last [2];
    logic                  skid_wp, skid_rp;
    logic [1:0]            skid_cnt;
    logic                  skid_empty, skid_push, skid_pop, beat_take;
    logic [1:0]            occupancy;
    logic                  credit;

    // The beat sitting in mem_q is older-than-nothing only when the skid
    // buffer is empty, so it is presented directly; otherwise the skid head is.
    assign skid_empty        = (skid_cnt == 2'd0);
    assign rd_data_valid_out = !skid_empty || mem_vld_q;
    assign rd_data_out       = !skid_empty ? skid_data[skid_rp] : (mem_vld_q ? mem_q      : '0);
    assign rd_data_id_out    = !skid_empty ? skid_id[skid_rp]   : (mem_vld_q ? mem_id_q   : '0);
    assign rd_data_last_out  = !skid_empty ? skid_last[skid_rp] : (mem_vld_q && mem_last_q);

    assign beat_take = rd_data_valid_out && rd_data_rdy_in;
    assign skid_push = mem_vld_q && !(skid_empty && beat_take);
    assign skid_pop  = !skid_empty && beat_take;

    // In-flight read plus buffered beats never exceeds two, so a stall can
    // always absorb every read already issued.
    assign occupancy = skid_cnt + {1'b0, mem_vld_q};
    assign credit    = (occupancy < 2'd2);

    always_ff @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (rd_issue)  mem_q <= mem[rd_word];
    end

    always_ff @(posedge clk) begin
        if (skid_push) begin
            skid_data[skid_wp] <= mem_q;
            skid_id[skid_wp]   <= mem_id_q;
            skid_last[skid_wp] <= mem_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_vld_q  <= 1'b0;
            mem_id_q   <= '0;
            mem_last_q <= 1'b0;
            skid_wp    <= 1'b0;
            skid_rp    <= 1'b0;
            skid_cnt   <= 2'd0;
        end else begin
            mem_vld_q <= rd_issue;
            if (rd_issue) begin
                mem_id_q   <= rd_beat_id;
                mem_last_q <= rd_beat_last;
            end
            if (skid_push) skid_wp <= ~skid_wp;
            if (skid_pop)  skid_rp <= ~skid_rp;
            case ({skid_push, skid_pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_word, cur_word_nxt;
    logic [7:0]            remain, remain_nxt;
    logic [5:0]            cur_id, cur_id_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cur_word <= '0;
            remain   <= '0;
            cur_id   <= '0;
        end else begin
            state    <= state_nxt;
            cur_word <= cur_word_nxt;
            remain   <= remain_nxt;
            cur_id   <= cur_id_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_word_nxt = cur_word;
        remain_nxt   = remain;
        cur_id_nxt   = cur_id;
        fifo_pop     = 1'b0;
        rd_issue     = 1'b0;
        rd_word      = cur_word;
        rd_beat_id   = cur_id;
        rd_beat_last = (remain == 8'd1);

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_len == 8'd0) begin
                        fifo_pop = 1'b1;
                    end else if (credit) begin
                        // First read comes straight from the FIFO head so a
                        // request reaches the output two cycles after acceptance.
                        fifo_pop     = 1'b1;
                        rd_issue     = 1'b1;
                        rd_word      = head_word;
                        rd_beat_id   = head_id;
                        rd_beat_last = (head_len == 8'd1);
                        cur_word_nxt = head_word + ADDR_WIDTH'(1);
                        remain_nxt   = head_len - 8'd1;
                        cur_id_nxt   = head_id;
                        if (head_len != 8'd1) state_nxt = S_BURST;
                    end
                end
            end

            S_BURST: begin
                if (credit) begin
                    rd_issue     = 1'b1;
                    cur_word_nxt = cur_word + ADDR_WIDTH'(1);
                    remain_nxt   = remain - 8'd1;
                    if (remain == 8'd1) begin
                        if (fifo_empty) begin
                            state_nxt = S_IDLE;
                        end else begin
                            // Chain the next burst with no bubble; a zero-length
                            // head is dropped here and IDLE picks up the rest.
                            fifo_pop = 1'b1;
                            if (head_len == 8'd0) begin
                                state_nxt = S_IDLE;
                            end else begin
                                cur_word_nxt = head_word;
                                remain_nxt   = head_len;
                                cur_id_nxt   = head_id;
                            end
                        end
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ref_mem_read_responder.sv
// Testbench for ref_mem_read_responder: directed requests with a scoreboard.
// The stimulus side pushes expected beats from a shadow copy of the preloaded
// memory; an independent monitor pops and compares every consumed beat.

module tb_ref_mem_read_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   rd_id_in;
    logic [31:0]  rd_addr_in;
    logic [7:0]   rd_len_in;
    logic         rd_info_valid_in;
    logic         rd_info_rdy_out;
    logic [255:0] rd_data_out;
    logic         rd_data_valid_out;
    logic         rd_data_rdy_in;
    logic [5:0]   rd_data_id_out;
    logic         rd_data_last_out;
    logic         mem_wr_en;
    logic [9:0]   mem_wr_addr;
    logic [255:0] mem_wr_data;

    ref_mem_read_responder #(.ADDR_WIDTH(10), .REQ_FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .rd_id_in          (rd_id_in),
        .rd_addr_in        (rd_addr_in),
        .rd_len_in         (rd_len_in),
        .rd_info_valid_in  (rd_info_valid_in),
        .rd_info_rdy_out   (rd_info_rdy_out),
        .rd_data_out       (rd_data_out),
        .rd_data_valid_out (rd_data_valid_out),
        .rd_data_rdy_in    (rd_data_rdy_in),
        .rd_data_id_out    (rd_data_id_out),
        .rd_data_last_out  (rd_data_last_out),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_data       (mem_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [5:0]   id;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    logic [255:0] shadow [1024];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           beats_seen = 0;
    int           run_len = 0;
    int           max_run = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [255:0] word_val(input int w);
        logic [255:0] v;
        v = '0;
        v[31:0]    = 32'h1000 + 32'(w);
        v[255:224] = 32'hC0DE_0000 + 32'(w);
        return v;
    endfunction

    task automatic preload(input int w, input logic [255:0] v);
        mem_wr_en   = 1'b1;
        mem_wr_addr = 10'(w);
        mem_wr_data = v;
        @(posedge clk); #1;
        mem_wr_en   = 1'b0;
        shadow[w]   = v;
    endtask

    task automatic send(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len, input int budget);
        logic r;
        bit   acc;
        int   base;
        beat_t e;
        acc = 0;
        rd_id_in = id; rd_addr_in = addr; rd_len_in = len; rd_info_valid_in = 1'b1;
        for (int n = 0; n < budget && !acc; n++) begin
            @(negedge clk); r = rd_info_rdy_out;
            @(posedge clk); #1;
            if (r) acc = 1;
        end
        rd_info_valid_in = 1'b0;
        chk("req_accept", 256'(acc), 256'(1));
        if (acc) begin
            base = int'(addr[14:5]);
            for (int k = 0; k < int'(len); k++) begin
                e.data = shadow[(base + k) % 1024];
                e.id   = id;
                e.last = (k == int'(len) - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rd_data_valid_out) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        chk(name, 256'(exp_q.size()), 256'(0));
    endtask

    // Monitor: compares every consumed beat and checks stall stability.
    logic         stall_prev = 1'b0;
    logic [255:0] hold_data;
    logic [5:0]   hold_id;
    logic         hold_last;
    beat_t        mon_e;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            run_len    = 0;
        end else begin
            if (rd_data_valid_out) run_len++; else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (stall_prev) begin
                chk("stall_valid", 256'(rd_data_valid_out), 256'(1));
                chk("stall_data", rd_data_out, hold_data);
                chk("stall_id_last", 256'({rd_data_id_out, rd_data_last_out}), 256'({hold_id, hold_last}));
            end
            if (rd_data_valid_out && rd_data_rdy_in) begin
                beats_seen++;
                chk("beat_expected", 256'(exp_q.size() != 0), 256'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", rd_data_out, mon_e.data);
                    chk("beat_id", 256'(rd_data_id_out), 256'(mon_e.id));
                    chk("beat_last", 256'(rd_data_last_out), 256'(mon_e.last));
                end
            end
            stall_prev = rd_data_valid_out && !rd_data_rdy_in;
            hold_data  = rd_data_out;
            hold_id    = rd_data_id_out;
            hold_last  = rd_data_last_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n;
    int base;

    initial begin
        rst = 1'b1;
        rd_id_in = '0; rd_addr_in = '0; rd_len_in = '0; rd_info_valid_in = 1'b0;
        rd_data_rdy_in = 1'b1;
        mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;

        // Reset values
        repeat (2) @(posedge clk); #1;
        chk("rst_info_rdy", 256'(rd_info_rdy_out), 256'(0));
        chk("rst_valid", 256'(rd_data_valid_out), 256'(0));
        chk("rst_data", rd_data_out, 256'(0));
        chk("rst_id_last", 256'({rd_data_id_out, rd_data_last_out}), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("info_rdy_after_rst", 256'(rd_info_rdy_out), 256'(1));
        @(posedge clk); #1;

        for (int w = 0; w < 16; w++) preload(w, word_val(w));
        for (int w = 1016; w < 1024; w++) preload(w, word_val(w));

        // Basic burst: words 2,3,4 -> 0x1002..0x1004, first valid two cycles after accept
        send(6'd5, 32'h40, 8'd3, 20);
        n = 0;
        do begin @(negedge clk); n++; end while (!rd_data_valid_out && n < 10);
        chk("first_beat_latency", 256'(n), 256'(2));
        chk("first_beat_low_word", 256'(rd_data_out[31:0]), 256'(32'h1002));
        @(posedge clk); #1;
        wait_drain("basic_drain", 50);

        // Backpressure: len 8 from word 0 with rdy pattern 1,0,0,1
        send(6'd7, 32'h0, 8'd8, 20);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || rd_data_valid_out); i++) begin
            rd_data_rdy_in = pat[i % 4];
            @(posedge clk); #1;
        end
        rd_data_rdy_in = 1'b1;
        chk("bp_drain", 256'(exp_q.size()), 256'(0));

        // Back-to-back: four len-2 bursts, expect one unbroken 8-beat run
        max_run = 0;
        for (int i = 1; i <= 4; i++) send(6'(i), 32'(i * 32'h100), 8'd2, 20);
        wait_drain("b2b_drain", 50);
        chk("b2b_run", 256'(max_run), 256'(8));

        // FIFO full: stall the first burst, then fill the FIFO
        rd_data_rdy_in = 1'b0;
        send(6'd10, 32'h0, 8'd3, 20);
        repeat (4) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            send(6'(11 + i), 32'(32'h80 + i * 32'h20), 8'd1, 5);
            @(negedge clk);
            chk("fill_info_rdy", 256'(rd_info_rdy_out), 256'(i < 3 ? 1 : 0));
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_info_rdy_low", 256'(rd_info_rdy_out), 256'(0));
        end
        @(posedge clk); #1;
        rd_data_rdy_in = 1'b1;
        send(6'd15, 32'h100, 8'd2, 30);
        wait_drain("full_drain", 60);

        // Boundaries: len 0 between len 1 requests, wrap at word 1023, ignored address bits
        base = beats_seen;
        send(6'd20, 32'h20, 8'd1, 20);
        send(6'd21, 32'h40, 8'd0, 20);
        send(6'd22, 32'h60, 8'd1, 20);
        send(6'd23, 32'h7FE0, 8'd2, 20);
        send(6'd24, 32'h8000_0045, 8'd1, 20);
        wait_drain("bound_drain", 60);
        chk("bound_beat_count", 256'(beats_seen - base), 256'(5));

        // Reset during a len-10 burst
        base = beats_seen;
        send(6'd30, 32'h0, 8'd10, 20);
        n = 0;
        while (beats_seen < base + 3 && n < 50) begin @(posedge clk); #1; n++; end
        chk("rst_beats_before", 256'(beats_seen - base), 256'(3));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_valid", 256'(rd_data_valid_out), 256'(0));
        chk("midrst_info_rdy", 256'(rd_info_rdy_out), 256'(0));
        rst = 1'b0;
        base = beats_seen;
        repeat (15) @(posedge clk); #1;
        chk("no_beats_after_rst", 256'(beats_seen), 256'(base));
        chk("valid_low_after_rst", 256'(rd_data_valid_out), 256'(0));

        // Memory kept across reset; word 3 rewritten to show preload still lands
        preload(3, {32'hFACE_0003, 192'h0, 32'h0000_BEEF});
        send(6'd31, 32'h40, 8'd2, 20);
        wait_drain("post_rst_drain", 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ref_mem_read_responder.md
Name: ref_mem_read_responder

Overview:
- Responder (slave) end of the DRAM read-burst interface that the reference reader drives: accepts read requests (ID, byte address, beat count) and returns 256-bit beats from an internal block-RAM image of DRAM.
- Used as the memory model and standalone stand-in for the AXI bus arbiter, so the reader/engine chain can be run without DRAM.
- A side write port preloads reference sequences.

Parameters:
- ADDR_WIDTH, 10: word-address bits of the internal memory (2^ADDR_WIDTH x 256-bit words).
- REQ_FIFO_DEPTH, 4: request FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- rd_id_in  in  6  read burst ID.
- rd_addr_in  in  32  read burst byte address.
- rd_len_in  in  8  burst length in 256-bit beats.
- rd_info_valid_in  in  1  request valid.
- rd_info_rdy_out  out  1  request accepted when high together with valid.
- rd_data_out  out  256  read data beat.
- rd_data_valid_out  out  1  beat valid.
- rd_data_rdy_in  in  1  beat consumed when high together with valid.
- rd_data_id_out  out  6  ID of the burst the current beat belongs to.
- rd_data_last_out  out  1  current beat is the final beat of its burst.
- mem_wr_en  in  1  preload write enable.
- mem_wr_addr  in  ADDR_WIDTH  preload word address.
- mem_wr_data  in  256  preload data.

Behaviour:
Reset values:
- rd_info_rdy_out = 0 during reset and 1 from the first cycle after rst drops.
- rd_data_valid_out = 0, rd_data_out = 0, rd_data_id_out = 0, rd_data_last_out = 0.
- Request FIFO emptied, burst state cleared to IDLE.
- Memory contents are not reset.

Address rules:
- Word address = rd_addr_in[ADDR_WIDTH+4:5]. Bits [4:0] are ignored, so there are no unaligned bursts.
- Higher address bits are ignored.
- Beat k of a burst reads word (base + k) mod 2^ADDR_WIDTH, so the address wraps.

Request side:
- A request is pushed into the FIFO on rd_info_valid_in & rd_info_rdy_out.
- rd_info_rdy_out = !full, derived from the registered occupancy only.
- When the FIFO is full, rdy is low even if a pop happens in the same cycle.

Burst state machine:
- IDLE: if the FIFO is not empty, pop the head and load base address, remaining count = rd_len, and ID.
  - If rd_len = 0, the request is discarded, no beats are produced, and the FSM stays in IDLE.
  - Otherwise go to BURST.
- BURST: issue one memory read per cycle while output buffer credit is available, increment the address, and decrement remaining.
  - When the final read issues: if the FIFO is not empty, pop and load the next request in the same cycle (no bubble between bursts); otherwise go to IDLE.

Memory and output path:
- Memory read latency is 1 cycle.
- Reads feed a 2-entry output skid buffer. A read issues only if the buffer has a free entry counting in-flight reads, so no beat is ever dropped.
- Latency: a request accepted in cycle T gives its first beat valid at T+2 at the earliest, when the FIFO was empty and IDLE.
- Throughput: one beat per cycle while rd_data_rdy_in stays high.
- While valid is high and rdy is low, rd_data_out, rd_data_id_out and rd_data_last_out hold stable, and valid does not drop.
- Beats leave strictly in request order. rd_data_last_out = 1 only on beat rd_len-1 of each burst.

Preload port:
- A write in cycle T is visible to reads issued at T+1 or later.
- A same-cycle read/write to the same word returns the old data.
- Preload writes are allowed at any time, including mid-burst.

Reset mid-operation:
- Aborts the current burst, flushes the FIFO and skid buffer, and drops valid on the next edge.
- Beats not yet delivered are lost.

Test Plan:
- Preload words 0..7 with the value 0x1000+i. Request id=5, addr=0x40, len=3, rdy held high. Required: beats 0x1002, 0x1003, 0x1004 with id=5, last asserted only on the third beat, first valid 2 cycles after acceptance.
- Backpressure: len=8 from addr 0 while toggling rd_data_rdy_in 1,0,0,1,...; required: all 8 beats delivered in order, each held stable across stall cycles, none duplicated or lost.
- Back-to-back: queue 4 requests (ids 1-4, len=2) with rdy high; required: 8 consecutive valid cycles with no bubble, and ids 1,1,2,2,3,3,4,4.
- FIFO full: hold rd_data_rdy_in=0 and push 5 requests; required: rd_info_rdy_out drops after 4 accepts (REQ_FIFO_DEPTH=4) and rises again after the first burst drains.
- Boundaries: len=0 request between two len=1 requests, then addr=0x7FE0 (word 1023) with len=2. Required: the len=0 request yields no beats, and the wrap request returns word 1023 then word 0.
- Reset mid-burst: apply rst for 1 cycle during beat 3 of a len=10 burst; required: valid=0 and rdy=0 in the reset cycle, no further beats, and a fresh request afterwards returns correct data because memory contents are retained.
